// File: rtl/c64_debug_pkg.sv
// Shared definitions for the UART debug bridge: host opcodes, FSM encoding
// and default response bytes.
package c64_debug_pkg;

    localparam logic [7:0] OP_RD   = 8'h01;
    localparam logic [7:0] OP_WR   = 8'h02;
    localparam logic [7:0] OP_BRD  = 8'h03;
    localparam logic [7:0] OP_BWR  = 8'h04;
    localparam logic [7:0] OP_PING = 8'h05;

    localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEF_VERSION  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_BUS,
        ST_TX
    } state_t;

endpackage

// File: rtl/c64_debug_bridge_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags the cycle in which LIMIT idle cycles have elapsed.
module c64_debug_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // A clear in the same cycle always wins, so a late byte is never abandoned.
    assign expire = enable && !clear && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/c64_debug_bridge.sv
// UART-to-debug-bus bridge: decodes host peek/poke/burst/ping commands and
// runs them over a request/ack bus, returning responses to the UART.
module c64_debug_bridge
    import c64_debug_pkg::*;
#(
    parameter int         ADDR_W   = 16,
    parameter int         TIMEOUT  = 1000000,
    parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE,
    parameter logic [7:0] VERSION  = DEF_VERSION
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx_byte_valid,
    input  logic [7:0]        uart_rx_byte,
    input  logic              uart_tx_busy,
    output logic              uart_tx_byte_valid,
    output logic [7:0]        uart_tx_byte,
    output logic [ADDR_W-1:0] debug_addr,
    output logic [7:0]        debug_data_o,
    input  logic [7:0]        debug_data_i,
    output logic              debug_we,
    output logic              debug_request,
    input  logic              debug_ack,
    output logic              rx_overrun
);

    localparam int NB = ADDR_W / 8;

    state_t            state, state_next;
    logic [7:0]        op;
    logic [1:0]        byte_cnt;
    logic [7:0]        count;      // remaining accesses; 0 encodes 256
    logic              we_q;
    logic              expire;
    logic              last;
    logic              is_read;
    logic              addr_done;
    logic [ADDR_W-1:0] addr_shift;

    assign last          = (count == 8'd1);
    assign is_read       = !we_q && (op != OP_PING);
    assign addr_done     = (byte_cnt == 2'(NB - 1));
    assign debug_request = (state == ST_BUS);
    assign debug_we      = we_q && (state == ST_BUS);

    if (ADDR_W > 8) begin : g_shift
        assign addr_shift = {debug_addr[ADDR_W-9:0], uart_rx_byte};
    end else begin : g_byte
        assign addr_shift = uart_rx_byte;
    end

    c64_debug_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (uart_rx_byte_valid),
        .enable (state == ST_ADDR || state == ST_LEN || state == ST_DATA),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (uart_rx_byte_valid) begin
                case (uart_rx_byte)
                    OP_RD, OP_WR, OP_BRD, OP_BWR: state_next = ST_ADDR;
                    OP_PING:                      state_next = ST_TX;
                    default:                      state_next = ST_IDLE;
                endcase
            end
            ST_ADDR: if (expire) begin
                state_next = ST_IDLE;
            end else if (uart_rx_byte_valid && addr_done) begin
                if (op == OP_RD)      state_next = ST_BUS;
                else if (op == OP_WR) state_next = ST_DATA;
                else                  state_next = ST_LEN;
            end
            ST_LEN: if (expire) begin
                state_next = ST_IDLE;
            end else if (uart_rx_byte_valid) begin
                state_next = (op == OP_BRD) ? ST_BUS : ST_DATA;
            end
            ST_DATA: if (expire) begin
                state_next = ST_IDLE;
            end else if (uart_rx_byte_valid) begin
                state_next = ST_BUS;
            end
            ST_BUS: if (debug_ack) begin
                state_next = (we_q && !last) ? ST_DATA : ST_TX;
            end
            ST_TX: if (!uart_tx_busy) begin
                state_next = (is_read && !last) ? ST_BUS : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op                 <= '0;
            byte_cnt           <= '0;
            count              <= '0;
            we_q               <= 1'b0;
            debug_addr         <= '0;
            debug_data_o       <= '0;
            uart_tx_byte       <= '0;
            uart_tx_byte_valid <= 1'b0;
            rx_overrun         <= 1'b0;
        end else begin
            uart_tx_byte_valid <= 1'b0;
            rx_overrun         <= uart_rx_byte_valid && (state == ST_BUS || state == ST_TX);
            case (state)
                ST_IDLE: if (uart_rx_byte_valid) begin
                    op       <= uart_rx_byte;
                    byte_cnt <= '0;
                    count    <= 8'd1;
                    we_q     <= (uart_rx_byte == OP_WR) || (uart_rx_byte == OP_BWR);
                    if (uart_rx_byte == OP_PING) uart_tx_byte <= VERSION;
                end
                ST_ADDR: if (uart_rx_byte_valid) begin
                    debug_addr <= addr_shift;
                    byte_cnt   <= byte_cnt + 1'b1;
                end
                ST_LEN:  if (uart_rx_byte_valid) count <= uart_rx_byte;
                ST_DATA: if (uart_rx_byte_valid) debug_data_o <= uart_rx_byte;
                ST_BUS: if (debug_ack) begin
                    if (we_q) begin
                        debug_addr <= debug_addr + 1'b1;
                        count      <= count - 8'd1;
                        if (last) uart_tx_byte <= ACK_BYTE;
                    end else begin
                        uart_tx_byte <= debug_data_i;
                    end
                end
                ST_TX: if (!uart_tx_busy) begin
                    uart_tx_byte_valid <= 1'b1;
                    if (is_read) begin
                        debug_addr <= debug_addr + 1'b1;
                        count      <= count - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/c64_debug_bridge.md
Name: c64_debug_bridge

Overview:
UART-to-bus debug bridge, next generation of the single-byte peek/poke monitor. Host commands arrive as bytes from the UART receiver. The bridge supports single and burst reads/writes with auto-increment, a configurable address width and a ping command. It drives the system debug bus port through a request/ack handshake and returns responses to the UART transmitter, with backpressure.

Parameters:
ADDR_W, 16, bus address width in bits; must be a multiple of 8 in the range 8..32; address bytes are sent MSB first.
TIMEOUT, 1000000, idle clocks between host bytes before the command is abandoned.
ACK_BYTE, 8'h06, write-completion response.
VERSION, 8'h02, byte returned by ping.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
uart_rx_byte_valid  in  1  one-cycle strobe: uart_rx_byte is valid
uart_rx_byte  in  8  received byte
uart_tx_busy  in  1  transmitter cannot accept a byte
uart_tx_byte_valid  out  1  one-cycle strobe: uart_tx_byte is valid
uart_tx_byte  out  8  byte to transmit
debug_addr  out  ADDR_W  bus address
debug_data_o  out  8  write data
debug_data_i  in  8  read data; valid in the cycle debug_ack is high
debug_we  out  1  1 = write access
debug_request  out  1  access request; held until ack
debug_ack  in  1  access complete
rx_overrun  out  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset (asynchronous, active-high) clears every output and register to 0 and puts the state machine in IDLE.
- Opcodes, decoded in IDLE:
  - 0x01 RD: addr.
  - 0x02 WR: addr, data.
  - 0x03 BRD: addr, len.
  - 0x04 BWR: addr, len, len data bytes.
  - 0x05 PING: no arguments.
  - Any other byte is ignored; the machine stays in IDLE.
- len is 8 bits; len 0 means 256 bytes. RD and WR are handled as len 1.
- States:
  - IDLE -> ADDR on a valid opcode. PING goes directly to TX with uart_tx_byte = VERSION.
  - ADDR shifts in ADDR_W/8 bytes. Then WR/BWR -> LEN or DATA; RD -> BUS; BRD -> LEN.
  - LEN -> BUS for BRD, DATA for BWR.
  - DATA latches the byte into debug_data_o -> BUS.
  - BUS holds debug_request and debug_we until debug_ack.
  - TX waits for !uart_tx_busy, then pulses uart_tx_byte_valid for one cycle.
- Latency:
  - debug_request rises on the cycle after the byte that completes the command or data phase.
  - In the ack cycle, read data is captured.
  - On the next cycle, debug_request falls and the machine enters TX (reads) or DATA/TX (writes).
- Burst read: each ack captures one byte and one byte is transmitted. Then debug_addr increments and the remaining count decrements. The next request is issued only after the byte has been transmitted.
- Burst write: each ack increments the address. After the final ack, ACK_BYTE is sent once. No per-byte ack.
- debug_addr increments modulo 2^ADDR_W, so all-ones wraps to 0.
- Timeout counter:
  - Cleared by every rx byte.
  - Counts only in ADDR, LEN and DATA.
  - When it reaches TIMEOUT, the machine returns to IDLE with no response and no bus access.
  - Never aborts BUS or TX.
- An rx byte arriving in BUS or TX is dropped, rx_overrun pulses, and state is unaffected.
- Holding debug_request through a long ack delay is legal; there is no bus timeout.
- An rx byte and debug_ack in the same cycle are legal: the byte is dropped (overrun) and the ack is processed.
- uart_tx_byte is stable from the cycle it is loaded until the valid strobe.

Decomposition:
- Shared package c64_debug_pkg holds:
  - opcode constants OP_RD, OP_WR, OP_BRD, OP_BWR, OP_PING;
  - state encodings;
  - default ACK_BYTE and VERSION.
- One sub-module is natural: c64_debug_timeout, a parametrised counter with inputs clear/enable and a one-cycle expire output.

Test Plan:
- RD: send 01 D0 20 with ack returning 8'h1B after 3 cycles -> one request with we=0 and addr 16'hD020; tx 1B; back in IDLE.
- WR: send 02 04 00 41 -> one request with we=1, addr 16'h0400, data 41; after ack, tx 06.
- BRD with wrap: send 03 FF FE 03, memory FFFE=11, FFFF=22, 0000=33, uart_tx_busy high for 5 cycles mid-burst -> tx 11 22 33 in order; addresses FFFE, FFFF, 0000; no request issued while a tx byte is pending.
- BWR len 0: send 04 C0 00 00 plus 256 data bytes -> 256 writes to C000..C0FF; exactly one 06 transmitted.
- Timeout: with TIMEOUT=50, send 01 D0, wait 60 cycles, send 05 -> no bus request; tx 02 (VERSION).
- Robustness:
  - Byte sent during BUS -> rx_overrun pulse, transaction unchanged.
  - Reset asserted while debug_request is high -> all outputs 0 immediately; the next command works normally.
